// File: rtl/matrix_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matrix_mac_sequencer                                            |
// | Brief    : Drives a 4x4 MAC array's enable/clear through K-pair jobs,      |
// |            with clear, drain and completion handshake phases.              |
// | Option   : MAC_SEQ_PERF_EN adds saturating perf_busy/perf_stall counters.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matrix_mac_sequencer #(
   parameter int LEN_WIDTH   = 8,
   parameter int MAC_LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [LEN_WIDTH-1:0] cmd_len,
   input  logic                 cmd_clear,
   input  logic                 abort,
   input  logic                 op_valid,
   output logic                 op_ready,
   output logic                 mac_enable,
   output logic                 mac_clear,
   output logic                 busy,
   output logic                 done_valid,
   input  logic                 done_ready,
`ifdef MAC_SEQ_PERF_EN
   output logic [31:0]          perf_busy,
   output logic [31:0]          perf_stall,
`endif
   output logic [LEN_WIDTH-1:0] done_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ACCUM = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int                 c_lat_w      = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
   localparam logic [c_lat_w-1:0] c_lat_last   = c_lat_w'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);
   // A zero-latency MAC has nothing to wait for, so accumulation goes straight to DONE.
   localparam state_t             c_after_acc  = (MAC_LATENCY == 0) ? S_DONE : S_DRAIN;

   state_t               r_state;
   state_t               w_next_state;
   logic [LEN_WIDTH-1:0] r_rem;
   logic [LEN_WIDTH-1:0] r_done_count;
   logic [c_lat_w-1:0]   r_lat;
   logic                 w_accept;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      cmd_ready    = 1'b0;
      op_ready     = 1'b0;
      mac_clear    = 1'b0;
      done_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = !abort;
            if (cmd_valid && !abort) begin
               w_accept = 1'b1;
               if (cmd_clear) begin
                  w_next_state = S_CLEAR;
               end else if (cmd_len != '0) begin
                  w_next_state = S_ACCUM;
               end else begin
                  w_next_state = c_after_acc;
               end
            end
         end
         S_CLEAR: begin
            mac_clear    = 1'b1;
            w_next_state = (r_rem != '0) ? S_ACCUM : c_after_acc;
         end
         S_ACCUM: begin
            op_ready = 1'b1;
            if (op_valid && (r_rem == LEN_WIDTH'(1))) begin
               w_next_state = c_after_acc;
            end
         end
         S_DRAIN: begin
            if (r_lat == c_lat_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            done_valid = 1'b1;
            if (done_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      // Abort overrides any transfer, drain end or handshake in flight.
      if (abort && (r_state != S_IDLE)) begin
         w_next_state = S_IDLE;
         mac_clear    = 1'b1;
         op_ready     = 1'b0;
         done_valid   = 1'b0;
      end
   end

   assign mac_enable = op_valid & op_ready;
   assign busy       = (r_state != S_IDLE);
   assign done_count = r_done_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rem        <= '0;
         r_done_count <= '0;
         r_lat        <= '0;
      end else begin
         if (w_accept) begin
            r_rem        <= cmd_len;
            r_done_count <= '0;
         end else if (mac_enable) begin
            r_rem        <= r_rem - 1'b1;
            r_done_count <= r_done_count + 1'b1;
         end
         r_lat <= ((r_state == S_DRAIN) && (w_next_state == S_DRAIN)) ? r_lat + 1'b1 : '0;
      end
   end

`ifdef MAC_SEQ_PERF_EN
   logic [31:0] r_perf_busy;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (busy && (r_perf_busy != '1)) begin
            r_perf_busy <= r_perf_busy + 1'b1;
         end
         if ((r_state == S_ACCUM) && !op_valid && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 1'b1;
         end
      end
   end

   assign perf_busy  = r_perf_busy;
   assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matrix_mac_sequencer                                         |
// | Brief    : Randomized self-checking bench with a job-timeline model.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_matrix_mac_sequencer;
   localparam int LEN_WIDTH   = 8;
   localparam int MAC_LATENCY = 1;

   logic                 clock      = 1'b0;
   logic                 reset      = 1'b0;
   logic                 cmd_valid  = 1'b0;
   logic                 cmd_clear  = 1'b0;
   logic                 abort      = 1'b0;
   logic                 op_valid   = 1'b0;
   logic                 done_ready = 1'b0;
   logic [LEN_WIDTH-1:0] cmd_len    = '0;
   logic                 cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid;
   logic [LEN_WIDTH-1:0] done_count;
`ifdef MAC_SEQ_PERF_EN
   logic [31:0]          perf_busy, perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   matrix_mac_sequencer #(.LEN_WIDTH(LEN_WIDTH), .MAC_LATENCY(MAC_LATENCY)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_clear  (cmd_clear),
      .abort      (abort),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .mac_enable (mac_enable),
      .mac_clear  (mac_clear),
      .busy       (busy),
      .done_valid (done_valid),
      .done_ready (done_ready),
`ifdef MAC_SEQ_PERF_EN
      .perf_busy  (perf_busy),
      .perf_stall (perf_stall),
`endif
      .done_count (done_count)
   );

   // Job timeline model: clear occupies cycle 1 when requested, accumulation
   // starts right after, and completion appears 1+MAC_LATENCY cycles after the
   // last transfer. pct<0 selects the fixed op_valid pattern in pat.
   task automatic run_job(input int len, input bit clr, input int pct, input logic [31:0] pat,
                          input int hold, input int abort_at, input string name);
      int         c, got, done_at, start_acc, stall_exp, en_seen;
      bit         in_acc, aborting, exp_done, fin, was_aborted;
      logic [5:0] exp_v, act_v;
`ifdef MAC_SEQ_PERF_EN
      logic [31:0] pb0, ps0;
`endif
      @(posedge clock); #1;
      cmd_valid  = 1'b1;
      cmd_len    = len[LEN_WIDTH-1:0];
      cmd_clear  = clr;
      abort      = 1'b0;
      done_ready = 1'($urandom % 2);
      op_valid   = 1'($urandom % 2);
      @(negedge clock);
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s accept: cmd_ready=%b busy=%b, required 1/0", name, cmd_ready, busy);
      end
`ifdef MAC_SEQ_PERF_EN
      pb0 = perf_busy;
      ps0 = perf_stall;
`endif
      start_acc   = clr ? 2 : 1;
      got         = 0;
      done_at     = (len == 0) ? start_acc + MAC_LATENCY : -1;
      stall_exp   = 0;
      en_seen     = 0;
      fin         = 1'b0;
      was_aborted = 1'b0;
      c           = 0;
      while (!fin) begin
         c++;
         @(posedge clock); #1;
         aborting = (c == abort_at);
         abort    = aborting;
         if (pct < 0) begin
            op_valid = (c >= start_acc && (c - start_acc) < 32) ? pat[c - start_acc] : 1'b0;
         end else begin
            op_valid = ($urandom_range(99) < pct);
         end
         if (done_at >= 0 && c >= done_at) begin
            cmd_valid  = (c < done_at + hold);
            done_ready = !(c < done_at + hold);
         end else begin
            cmd_valid  = 1'($urandom % 2);
            done_ready = 1'($urandom % 2);
         end
         @(negedge clock);
         in_acc   = (c >= start_acc) && (got < len);
         exp_done = (done_at >= 0) && (c >= done_at) && !aborting;
         exp_v    = {1'b0, in_acc && !aborting, in_acc && !aborting && op_valid,
                     (clr && c == 1) || aborting, 1'b1, exp_done};
         act_v    = {cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d {cmd_rdy,op_rdy,en,clr,busy,done}: got %b, required %b",
                     name, c, act_v, exp_v);
         end
         if (exp_done) begin
            n_checks++;
            if (done_count !== LEN_WIDTH'(len)) begin
               n_fail++;
               $display("FAIL %s done_count cycle %0d: got %0d, required %0d", name, c, done_count, len);
            end
         end
         if (mac_enable === 1'b1) en_seen++;
         if (in_acc && !op_valid) stall_exp++;
         if (in_acc && !aborting && op_valid) begin
            got++;
            if (got == len) done_at = c + 1 + MAC_LATENCY;
         end
         if (aborting) was_aborted = 1'b1;
         if (aborting || (exp_done && c >= done_at + hold)) fin = 1'b1;
         if (c > 5000) begin
            n_fail++;
            $display("FAIL %s timeout: no completion after %0d cycles, required within budget", name, c);
            fin = 1'b1;
         end
      end
      @(posedge clock); #1;
      abort      = 1'b0;
      cmd_valid  = 1'b0;
      done_ready = 1'b0;
      op_valid   = 1'($urandom % 2);
      @(negedge clock);
      act_v = {cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid};
      n_checks++;
      if (act_v !== 6'b100000) begin
         n_fail++;
         $display("FAIL %s idle after job: got %b, required 100000", name, act_v);
      end
      if (!was_aborted) begin
         n_checks++;
         if (en_seen != len) begin
            n_fail++;
            $display("FAIL %s mac_enable pulses: got %0d, required %0d", name, en_seen, len);
         end
      end
`ifdef MAC_SEQ_PERF_EN
      n_checks++;
      if ((perf_busy - pb0) !== 32'(c) || (perf_stall - ps0) !== 32'(stall_exp)) begin
         n_fail++;
         $display("FAIL %s perf deltas busy/stall: got %0d/%0d, required %0d/%0d",
                  name, perf_busy - pb0, perf_stall - ps0, c, stall_exp);
      end
`endif
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid} !== 6'b100000 ||
          done_count !== '0) begin
         n_fail++;
         $display("FAIL reset outputs: got %b count %0d, required 100000 count 0",
                  {cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid}, done_count);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      run_job(4, 1'b1, 100, 32'd0, 0, 0, "basic_len4_clear");
      run_job(3, 1'b0, -1, 32'b11001, 0, 0, "stall_pattern");
   endtask

   task automatic test_zero_len();
      run_job(0, 1'b0, 100, 32'd0, 0, 0, "zero_len");
      run_job(0, 1'b1, 100, 32'd0, 1, 0, "zero_len_clear");
   endtask

   task automatic test_done_hold();
      run_job(2, 1'b0, 100, 32'd0, 10, 0, "done_hold");
   endtask

   task automatic test_abort();
      run_job(5, 1'b0, 100, 32'd0, 0, 3, "abort_after_2");
      run_job(5, 1'b0, 100, 32'd0, 0, 0, "after_abort");
      @(posedge clock); #1;
      cmd_valid = 1'b1;
      cmd_len   = 8'd3;
      abort     = 1'b1;
      @(negedge clock);
      n_checks++;
      if (cmd_ready !== 1'b0 || mac_clear !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_abort: cmd_ready=%b mac_clear=%b busy=%b, required 0/0/0",
                  cmd_ready, mac_clear, busy);
      end
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_abort_no_accept: busy=%b, required 0", busy);
      end
      run_job(2, 1'b0, 100, 32'd0, 2, 4, "abort_in_done");
      run_job(2, 1'b1, 100, 32'd0, 0, 1, "abort_in_clear");
   endtask

   task automatic test_max_len();
      run_job(255, 1'b1, 100, 32'd0, 0, 0, "max_len");
   endtask

   task automatic test_random();
      for (int j = 0; j < 25; j++) begin
         int len, ab;
         len = $urandom_range(20);
         ab  = ($urandom % 4 == 0) ? int'($urandom_range(30, 1)) : 0;
         run_job(len, 1'($urandom % 2), int'($urandom_range(100, 30)), 32'd0,
                 int'($urandom_range(3)), ab, "random_job");
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clock); #1;
      cmd_valid = 1'b1;
      cmd_len   = 8'd8;
      cmd_clear = 1'b0;
      op_valid  = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid} !== 6'b100000 ||
          done_count !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_accum: got %b count %0d, required 100000 count 0",
                  {cmd_ready, op_ready, mac_enable, mac_clear, busy, done_valid}, done_count);
      end
      @(negedge clock);
      reset = 1'b1;
      run_job(6, 1'b1, 70, 32'd0, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_done_hold();
      test_abort();
      test_max_len();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
